// File: rtl/spi_cfg_loader_if.sv
// Parallel request side of the SPI configuration loader: one frame per valid/ready handshake.
interface spi_cfg_loader_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] TX_DATA;
    logic              TX_REGSEL;
    logic              TX_MODE;
    logic              TX_VALID;
    logic              TX_READY;

    modport master (output TX_DATA, TX_REGSEL, TX_MODE, TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, TX_REGSEL, TX_MODE, TX_VALID, output TX_READY);
endinterface

// File: rtl/spi_cfg_loader.sv
// Shifts DATA_W-bit words MSB-first into a chip shift register on a divided serial clock,
// reads the chip register back on SOUT, and sequences the chip power-on GRST pulse.
module spi_cfg_loader #(
    parameter int DATA_W     = 32,
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 16
) (
    input  logic              SCLK,
    input  logic              RST,
    spi_cfg_loader_if.slave   tx,
    input  logic              SOUT,
    output logic              SIN,
    output logic              clk,
    output logic              REGSEL,
    output logic              GRST,
    output logic              LOAD,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              BUSY
);
    localparam int PH_W = $clog2(2 * CLK_DIV);
    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    localparam logic [PH_W-1:0] PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
    localparam logic [RC_W-1:0] RC_END   = RC_W'(RST_CYCLES);

    typedef enum logic [1:0] {GRST_HOLD, IDLE, SHIFT, LATCH} state_t;

    state_t            state;
    logic [RC_W-1:0]   rst_cnt;
    logic [PH_W-1:0]   phase;
    logic [BC_W-1:0]   bitc;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              mode;

    logic [DATA_W-1:0] tx_nxt;
    logic [DATA_W-1:0] rx_nxt;
    assign tx_nxt = tx_sh << 1;
    assign rx_nxt = (rx_sh << 1) | DATA_W'(SOUT);

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state       <= GRST_HOLD;
            rst_cnt     <= '0;
            phase       <= '0;
            bitc        <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            mode        <= 1'b0;
            GRST        <= 1'b0;
            clk         <= 1'b0;
            SIN         <= 1'b0;
            REGSEL      <= 1'b0;
            LOAD        <= 1'b0;
            RX_VALID    <= 1'b0;
            RX_DATA     <= '0;
            tx.TX_READY <= 1'b0;
            BUSY        <= 1'b1;
        end else begin
            LOAD     <= 1'b0;
            RX_VALID <= 1'b0;
            case (state)
                GRST_HOLD: begin
                    if (rst_cnt == RC_END) begin
                        GRST        <= 1'b1;
                        tx.TX_READY <= 1'b1;
                        BUSY        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                IDLE: begin
                    if (tx.TX_VALID) begin
                        tx_sh       <= tx.TX_DATA;
                        SIN         <= tx.TX_DATA[DATA_W-1];
                        REGSEL      <= tx.TX_REGSEL;
                        mode        <= tx.TX_MODE;
                        phase       <= '0;
                        bitc        <= '0;
                        rx_sh       <= '0;
                        tx.TX_READY <= 1'b0;
                        BUSY        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    // SOUT is taken on the edge that raises clk, before the chip reacts to it
                    if (phase == PH_RISE) begin
                        clk   <= 1'b1;
                        rx_sh <= rx_nxt;
                    end
                    if (phase == PH_LAST) begin
                        clk   <= 1'b0;
                        phase <= '0;
                        if (bitc == BIT_LAST) begin
                            RX_DATA  <= rx_sh;
                            RX_VALID <= 1'b1;
                            LOAD     <= ~mode;
                            state    <= LATCH;
                        end else begin
                            bitc  <= bitc + BC_W'(1);
                            tx_sh <= tx_nxt;
                            SIN   <= tx_nxt[DATA_W-1];
                        end
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                LATCH: begin
                    REGSEL      <= 1'b0;
                    SIN         <= 1'b0;
                    tx.TX_READY <= 1'b1;
                    BUSY        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= GRST_HOLD;
            endcase
        end
    end
endmodule
